// File: rtl/spi_slave_byte.sv
// Byte-oriented SPI mode-0 slave, MSB first, oversampled on clk; valid/ready rx and tx sides.
// Define SPI_SLAVE_MISO_OE_EN to add a miso_oe output for tristating a shared MISO line.
module spi_slave_byte #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEFAULT_TX  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       underrun
`ifdef SPI_SLAVE_MISO_OE_EN
  ,
  output logic       miso_oe
`endif
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  logic [NS-1:0] ss_sync, sclk_sync, mosi_sync;
  logic          ss_s, sclk_s, mosi_s;
  logic          ss_hist, sclk_hist, mosi_hist;
  logic          ss_fall, ss_rise, sclk_rise, sclk_fall;
  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] rx_shift, tx_shift, hold_data;
  logic          reload;
  logic [DW-1:0] next_tx;

  assign ss_s   = ss_sync[NS-1];
  assign sclk_s = sclk_sync[NS-1];
  assign mosi_s = mosi_sync[NS-1];

  // Byte to present at a byte boundary: held byte if one is queued, otherwise the filler.
  assign next_tx = tx_ready ? DEFAULT_TX : hold_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_hist   <= 1'b1;
      sclk_hist <= 1'b0;
      mosi_hist <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      hold_data <= '0;
      reload    <= 1'b0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
      miso_oe   <= 1'b0;
`endif
    end else begin
      ss_sync   <= {ss_sync[NS-2:0], ss};
      sclk_sync <= {sclk_sync[NS-2:0], sclk};
      mosi_sync <= {mosi_sync[NS-2:0], mosi};
      ss_hist   <= ss_s;
      sclk_hist <= sclk_s;
      mosi_hist <= mosi_s;
      // Registered edge strobes; mosi_hist stays aligned with sclk_rise.
      ss_fall   <= ss_hist & ~ss_s;
      ss_rise   <= ~ss_hist & ss_s;
      sclk_rise <= ~sclk_hist & sclk_s;
      sclk_fall <= sclk_hist & ~sclk_s;

      overrun  <= 1'b0;
      underrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state <= LOAD;
            busy  <= 1'b1;
`ifdef SPI_SLAVE_MISO_OE_EN
            miso_oe <= 1'b1;
`endif
          end
        end
        LOAD: begin
          if (ss_rise) begin
            state <= IDLE;
            busy  <= 1'b0;
            miso  <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
            miso_oe <= 1'b0;
`endif
          end else begin
            tx_shift <= next_tx;
            miso     <= next_tx[DW-1];
            if (tx_ready) underrun <= 1'b1;
            else          tx_ready <= 1'b1;
            bit_cnt <= '0;
            reload  <= 1'b0;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            // Abort: any partial byte is dropped silently.
            state   <= IDLE;
            busy    <= 1'b0;
            miso    <= 1'b0;
            bit_cnt <= '0;
            reload  <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
            miso_oe <= 1'b0;
`endif
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DW-2:0], mosi_hist};
            if (bit_cnt == CW'(DW - 1)) begin
              rx_data  <= {rx_shift[DW-2:0], mosi_hist};
              rx_valid <= 1'b1;
              overrun  <= rx_valid & ~rx_ready;
              bit_cnt  <= '0;
              reload   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (sclk_fall) begin
            if (reload) begin
              tx_shift <= next_tx;
              miso     <= next_tx[DW-1];
              if (tx_ready) underrun <= 1'b1;
              else          tx_ready <= 1'b1;
              reload <= 1'b0;
            end else if (bit_cnt != '0) begin
              tx_shift <= {tx_shift[DW-2:0], 1'b0};
              miso     <= tx_shift[DW-2];
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Accept after the load logic so a same-cycle load sees the old holding state.
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        tx_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: a mode-0 master, table-driven single-byte frames,
// hand-written multi-byte/abort/reset sequences and randomized frames against a slot model.
module tb_spi_slave_byte;

  localparam int unsigned SYNC = 2;
  localparam logic [7:0]  DEF  = 8'h3C;

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi, miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, busy, overrun, underrun;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic       miso_oe;
  logic       oe_seen;
`endif

  spi_slave_byte #(.SYNC_STAGES(SYNC), .DEFAULT_TX(DEF)) dut (
    .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .underrun(underrun)
`ifdef SPI_SLAVE_MISO_OE_EN
    , .miso_oe(miso_oe)
`endif
  );

  always #10 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] mt [8];
  logic [7:0] mr [8];
  logic       push_en [8];
  logic [7:0] push_val [8];
  logic       abort_pre, abort_miso, abort_busy;

  // Observer of handshakes and pulses (values seen just before each edge).
  logic [7:0] got [$];
  int         over_cnt = 0;
  int         under_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (overrun) over_cnt++;
      if (underrun) under_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] v, input string nm);
    check(nm, 32'(tx_ready), 32'd1);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Mode-0 master: clk/8 sclk, last falling edge coincides with ss release.
  task automatic master_frame(input int n, input int abort_rises);
    int rises;
    bit done;
    rises = 0;
    done  = 1'b0;
    ss    = 1'b0;
    mosi  = mt[0][7];
    repeat (8) @(negedge clk);
    for (int b = 0; b < n && !done; b++) begin
      for (int i = 7; i >= 0 && !done; i--) begin
        mosi = mt[b][i];
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        mr[b][i] = miso;
`ifdef SPI_SLAVE_MISO_OE_EN
        if (b == 0 && i == 7) oe_seen = miso_oe;
`endif
        rises++;
        if (i == 4 && push_en[b]) begin
          push_tx(push_val[b], "tx_ready_mid_frame");
          repeat (3) @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
        if (rises == abort_rises) begin
          abort_pre = miso;
          ss = 1'b1;
          sclk = 1'b0;
          done = 1'b1;
          repeat (SYNC + 2) @(negedge clk);
          abort_miso = miso;
          abort_busy = busy;
        end else if (b == n - 1 && i == 0) begin
          ss = 1'b1;
          sclk = 1'b0;
        end else begin
          sclk = 1'b0;
        end
      end
    end
    repeat (8) @(negedge clk);
    for (int k = 0; k < 8; k++) push_en[k] = 1'b0;
  endtask

  typedef struct {
    logic [7:0] mosi_b;
    logic       queue_tx;
    logic [7:0] tx_b;
    logic [7:0] exp_rx;
    logic [7:0] exp_master;
    int         exp_under;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int base, bu, bo, n;
    logic pre;
    logic [7:0] pre_v, slot;
    logic ready;

    vecs[0] = '{8'hAD, 1'b1, 8'hCA, 8'hAD, 8'hCA, 0};
    vecs[1] = '{8'h00, 1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[2] = '{8'hFF, 1'b0, 8'h00, 8'hFF, DEF,   1};
    vecs[3] = '{8'h81, 1'b1, 8'h7E, 8'h81, 8'h7E, 0};

    rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    for (int k = 0; k < 8; k++) begin push_en[k] = 1'b0; push_val[k] = 8'h00; end
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(miso), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_tx_ready", 32'(tx_ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_overrun", 32'(overrun), 0);
    check("reset_underrun", 32'(underrun), 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("reset_miso_oe", 32'(miso_oe), 0);
`endif
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte frames from the table.
    foreach (vecs[v]) begin
      base = got.size(); bu = under_cnt; bo = over_cnt;
      if (vecs[v].queue_tx) push_tx(vecs[v].tx_b, "tx_ready_pre");
      mt[0] = vecs[v].mosi_b;
      master_frame(1, 0);
      check("vec_rx_count", 32'(got.size() - base), 1);
      check("vec_rx_data", 32'((got.size() > base) ? got[base] : 8'hxx), 32'(vecs[v].exp_rx));
      check("vec_master_rx", 32'(mr[0]), 32'(vecs[v].exp_master));
      check("vec_underrun", 32'(under_cnt - bu), 32'(vecs[v].exp_under));
      check("vec_overrun", 32'(over_cnt - bo), 0);
      check("vec_tx_ready", 32'(tx_ready), 1);
      check("vec_busy_idle", 32'(busy), 0);
`ifdef SPI_SLAVE_MISO_OE_EN
      check("vec_oe_in_frame", 32'(oe_seen), 1);
      check("vec_oe_idle", 32'(miso_oe), 0);
`endif
    end

    // Back-to-back bytes in one frame, second tx byte queued while busy.
    base = got.size(); bu = under_cnt; bo = over_cnt;
    push_tx(8'h11, "b2b_tx_ready");
    mt[0] = 8'h5A; mt[1] = 8'hA5;
    push_en[0] = 1'b1; push_val[0] = 8'h22;
    master_frame(2, 0);
    check("b2b_rx_count", 32'(got.size() - base), 2);
    check("b2b_rx0", 32'((got.size() > base) ? got[base] : 8'hxx), 32'h5A);
    check("b2b_rx1", 32'((got.size() > base + 1) ? got[base + 1] : 8'hxx), 32'hA5);
    check("b2b_master0", 32'(mr[0]), 32'h11);
    check("b2b_master1", 32'(mr[1]), 32'h22);
    check("b2b_underrun", 32'(under_cnt - bu), 0);
    check("b2b_overrun", 32'(over_cnt - bo), 0);

    // Underrun and overrun: nothing queued, consumer stalled.
    base = got.size(); bu = under_cnt; bo = over_cnt;
    rx_ready = 1'b0;
    mt[0] = 8'h96; mt[1] = 8'h3B;
    master_frame(2, 0);
    check("uo_master0", 32'(mr[0]), 32'(DEF));
    check("uo_master1", 32'(mr[1]), 32'(DEF));
    check("uo_underrun", 32'(under_cnt - bu), 2);
    check("uo_overrun", 32'(over_cnt - bo), 1);
    check("uo_rx_data", 32'(rx_data), 32'h3B);
    check("uo_rx_valid", 32'(rx_valid), 1);
    check("uo_no_reads", 32'(got.size() - base), 0);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("uo_drain_valid", 32'(rx_valid), 0);
    check("uo_drain_data", 32'(got[got.size() - 1]), 32'h3B);

    // Abort after 5 rising edges, then a clean frame.
    base = got.size();
    push_tx(8'hFF, "abort_tx_ready");
    mt[0] = 8'hC3;
    master_frame(1, 5);
    check("abort_miso_before", 32'(abort_pre), 1);
    check("abort_miso_after", 32'(abort_miso), 0);
    check("abort_busy_after", 32'(abort_busy), 0);
    check("abort_no_rx", 32'(got.size() - base), 0);
    check("abort_rx_valid", 32'(rx_valid), 0);
    push_tx(8'h5E, "post_abort_tx_ready");
    mt[0] = 8'hE7;
    master_frame(1, 0);
    check("post_abort_rx", 32'((got.size() > base) ? got[base] : 8'hxx), 32'hE7);
    check("post_abort_master", 32'(mr[0]), 32'h5E);

    // Reset during bit 3 with rx_valid set and a byte held.
    rx_ready = 1'b0;
    push_tx(8'h42, "rst_pre_tx_ready");
    mt[0] = 8'h99;
    master_frame(1, 0);
    check("rst_pre_rx_valid", 32'(rx_valid), 1);
    ss = 1'b0; mosi = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      if (i == 0) push_tx(8'h66, "rst_mid_tx_ready");
      else @(negedge clk);
      repeat (3) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("rst_pre_tx_full", 32'(tx_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_miso", 32'(miso), 0);
    check("rst_mid_rx_data", 32'(rx_data), 0);
    check("rst_mid_rx_valid", 32'(rx_valid), 0);
    check("rst_mid_tx_ready", 32'(tx_ready), 1);
    check("rst_mid_busy", 32'(busy), 0);
    rst = 1'b1; ss = 1'b1; sclk = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_stays_idle", 32'(busy), 0);
    check("rst_no_rx", 32'(rx_valid), 0);
    rx_ready = 1'b1;
    base = got.size();
    push_tx(8'h77, "rst_post_tx_ready");
    mt[0] = 8'h1E;
    master_frame(1, 0);
    check("rst_post_rx", 32'((got.size() > base) ? got[base] : 8'hxx), 32'h1E);
    check("rst_post_master", 32'(mr[0]), 32'h77);

    // Randomized frames: each byte slot carries the byte queued for it, else DEF.
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 3);
      pre = 1'($urandom_range(0, 1));
      pre_v = 8'($urandom);
      ready = 1'($urandom_range(0, 1));
      for (int b = 0; b < n; b++) begin
        mt[b] = 8'($urandom);
        push_en[b] = (b < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        push_val[b] = 8'($urandom);
      end
      base = got.size(); bu = under_cnt; bo = over_cnt;
      rx_ready = ready;
      if (pre) push_tx(pre_v, "rnd_pre_tx_ready");
      begin
        int exp_under;
        logic [7:0] exp_slot [8];
        exp_under = 0;
        for (int b = 0; b < n; b++) begin
          if (b == 0) slot = pre ? pre_v : DEF;
          else        slot = push_en[b - 1] ? push_val[b - 1] : DEF;
          if ((b == 0 && !pre) || (b > 0 && !push_en[b - 1])) exp_under++;
          exp_slot[b] = slot;
        end
        master_frame(n, 0);
        for (int b = 0; b < n; b++) check("rnd_master_rx", 32'(mr[b]), 32'(exp_slot[b]));
        check("rnd_underrun", 32'(under_cnt - bu), 32'(exp_under));
      end
      if (ready) begin
        check("rnd_rx_count", 32'(got.size() - base), 32'(n));
        for (int b = 0; b < n; b++)
          check("rnd_rx_data", 32'((got.size() > base + b) ? got[base + b] : 8'hxx), 32'(mt[b]));
        check("rnd_overrun", 32'(over_cnt - bo), 0);
      end else begin
        check("rnd_stall_no_reads", 32'(got.size() - base), 0);
        check("rnd_stall_overrun", 32'(over_cnt - bo), 32'(n - 1));
        check("rnd_stall_rx_data", 32'(rx_data), 32'(mt[n - 1]));
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rnd_stall_drain", 32'(got.size() - base), 1);
        check("rnd_stall_valid", 32'(rx_valid), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
